// File: rtl/lag_pl_alloc_arbiter_pkg.sv
// Shared constants and helpers for the per-output-port PL allocation arbiter.
// The PL vector width is router-global; the id type is derived from it.
package lag_pl_alloc_arbiter_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int NUM_PLS_GLOBAL = 4;
  localparam int PL_ID_W        = clog2(NUM_PLS_GLOBAL);

  typedef logic [PL_ID_W-1:0]        pl_t;
  typedef logic [NUM_PLS_GLOBAL-1:0] pl_vec_t;

  // Bits below n are usable at a port with only n local PLs.
  function automatic pl_vec_t pl_local_mask(input int n);
    pl_vec_t m;
    m = '0;
    for (int i = 0; i < NUM_PLS_GLOBAL; i++) m[i] = (i < n);
    return m;
  endfunction

endpackage

// File: rtl/lag_pl_alloc_arbiter_if.sv
// Request/free-pool side of the PL allocation arbiter; master = requesters + free pool,
// slave = arbiter. Grant outputs are registered in the arbiter.
interface lag_pl_alloc_arbiter_if #(
  parameter int NUM_REQ = 5
);
  import lag_pl_alloc_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  pl_vec_t            pl_alloc_status;
  logic [NUM_REQ-1:0] grant;
  pl_t                grant_pl_id;
  pl_vec_t            pl_allocated;
  logic               busy;

  modport master (
    output req, pl_alloc_status,
    input  grant, grant_pl_id, pl_allocated, busy
  );

  modport slave (
    input  req, pl_alloc_status,
    output grant, grant_pl_id, pl_allocated, busy
  );

endinterface

// File: rtl/lag_pl_alloc_arbiter_rr.sv
// Round-robin requester pick (combinational) with a registered priority pointer that
// advances past the winner only when update_i is set.
module lag_pl_alloc_arbiter_rr
  import lag_pl_alloc_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               update_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int IDX_W = clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q, ptr_d, win_idx;

  always_comb begin
    int               idx;
    logic             found;
    logic [IDX_W-1:0] sel;
    gnt_o   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IDX_W'(idx);
      if (!found && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        win_idx    = sel;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_i) begin
      ptr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lag_pl_alloc_arbiter.sv
// Per-output-port PL allocator: one round-robin requester and the lowest free PL per cycle,
// registered (latency 1). Requests wait (busy) while no PL is free; no PL is issued twice.
module lag_pl_alloc_arbiter
  import lag_pl_alloc_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 5,
  parameter int NUM_PLS_LOCAL = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lag_pl_alloc_arbiter_if.slave  arb_if
);

  localparam pl_vec_t LOCAL_MASK = pl_local_mask(NUM_PLS_LOCAL);

  logic [NUM_REQ-1:0] grant_q, grant_d, eff_req, rr_gnt;
  pl_vec_t            pl_allocated_q, pl_allocated_d, eff_free;
  pl_t                grant_pl_id_q, grant_pl_id_d, pl_sel;
  logic               busy_q, busy_d, do_grant;

  // Last cycle's grant is still visible upstream: hide that requester and that PL.
  assign eff_req  = arb_if.req & ~grant_q;
  assign eff_free = arb_if.pl_alloc_status & ~pl_allocated_q & LOCAL_MASK;
  assign do_grant = (|eff_req) && (|eff_free);

  always_comb begin
    pl_sel = '0;
    for (int i = NUM_PLS_GLOBAL - 1; i >= 0; i--) begin
      if (eff_free[i]) pl_sel = pl_t'(i);
    end
  end

  lag_pl_alloc_arbiter_rr #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (eff_req),
    .update_i (do_grant),
    .gnt_o    (rr_gnt)
  );

  always_comb begin
    grant_d        = '0;
    grant_pl_id_d  = '0;
    pl_allocated_d = '0;
    busy_d         = 1'b0;
    if (do_grant) begin
      grant_d                = rr_gnt;
      grant_pl_id_d          = pl_sel;
      pl_allocated_d[pl_sel] = 1'b1;
    end else begin
      busy_d = |eff_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q        <= '0;
      grant_pl_id_q  <= '0;
      pl_allocated_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      grant_q        <= grant_d;
      grant_pl_id_q  <= grant_pl_id_d;
      pl_allocated_q <= pl_allocated_d;
      busy_q         <= busy_d;
    end
  end

  assign arb_if.grant        = grant_q;
  assign arb_if.grant_pl_id  = grant_pl_id_q;
  assign arb_if.pl_allocated = pl_allocated_q;
  assign arb_if.busy         = busy_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_alloc_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(pl_allocated_q));
  a_pl_local:     assert property (@(posedge clk) disable iff (!rst_n)
                                   (|grant_q) |-> (int'(grant_pl_id_q) < NUM_PLS_LOCAL));
  a_pl_was_free:  assert property (@(posedge clk) disable iff (!rst_n)
                                   do_grant |-> arb_if.pl_alloc_status[pl_sel]);
  a_alloc_match:  assert property (@(posedge clk) disable iff (!rst_n)
                                   (|grant_q) |-> (pl_allocated_q == (pl_vec_t'(1) << grant_pl_id_q)));

endmodule
